// File: rtl/secuenciador_rtc_if.sv
// rtl/secuenciador_rtc_if.sv - user write-request bundle for the RTC register sequencer
//
// Purpose: carries one pending RTC register write from the user-edit logic
//          to the sequencer.
// Signals:
//   wr_req   level, write pending; the requester holds it until wr_ack
//   wr_addr  RTC register address for the write
//   wr_data  byte to write
//   wr_ack   1-cycle pulse in the last cycle of the write slot
// Modports: master = requester, slave = sequencer.
interface secuenciador_rtc_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/secuenciador_rtc.sv
// rtl/secuenciador_rtc.sv - slot sequencer sweeping RTC registers into a shadow bank
//
// Purpose: drives the RTC protocol engine in fixed TRANS_CYCLES-long slots.
//          Read slots sweep the time/date/timer registers and capture data_vga
//          into a shadow bank. A pending user write is inserted as a single
//          write slot between two read slots.
// Ports:
//   clk, reset (synchronous, active-low)
//   wr                 write-request interface (slave side)
//   address            protocol engine address
//   data_write         protocol engine DATA_WRITE (0 in read slots)
//   indicador_maquina  1 = write slot, 0 = read slot
//   data_vga           byte returned by the protocol engine
//   seg..hora_t        shadow register bank
//   frame_valid        1-cycle pulse when bank[8] (the end of a sweep) is captured
// Optional: SECUENCIADOR_INIT_EN inserts two start-up write slots
//           (0x02 <- 0x10, then 0x00 <- 0x00) before the first read slot.
module secuenciador_rtc #(
  parameter int TRANS_CYCLES = 256,
  parameter int N_REGS       = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  secuenciador_rtc_if.slave        wr,
  output logic [7:0]               address,
  output logic [7:0]               data_write,
  output logic                     indicador_maquina,
  input  logic [7:0]               data_vga,
  output logic [7:0]               seg,
  output logic [7:0]               min,
  output logic [7:0]               hora,
  output logic [7:0]               dia,
  output logic [7:0]               mes,
  output logic [7:0]               anio,
  output logic [7:0]               seg_t,
  output logic [7:0]               min_t,
  output logic [7:0]               hora_t,
  output logic                     frame_valid
);

  localparam int CW = $clog2(TRANS_CYCLES);

  typedef enum logic [1:0] {RST_WAIT, READ, WRITE, INIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    ptr;
  logic [7:0]    bank [0:N_REGS-1];
`ifdef SECUENCIADOR_INIT_EN
  logic          init_step;
`endif

  logic       slot_end;
  logic       ack_next;
  logic       ptr_last;
  logic [3:0] ptr_next;

  // Fixed sweep map: time/date block at 0x21.., timer block at 0x41..
  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h21;
      4'd1:    reg_addr = 8'h22;
      4'd2:    reg_addr = 8'h23;
      4'd3:    reg_addr = 8'h24;
      4'd4:    reg_addr = 8'h25;
      4'd5:    reg_addr = 8'h26;
      4'd6:    reg_addr = 8'h41;
      4'd7:    reg_addr = 8'h42;
      4'd8:    reg_addr = 8'h43;
      default: reg_addr = 8'h21;
    endcase
  endfunction

  assign slot_end = (cnt == CW'(TRANS_CYCLES - 1));
  // wr_ack is registered, so it is set one cycle early to land on the last slot cycle
  assign ack_next = (cnt == CW'(TRANS_CYCLES - 2));
  assign ptr_last = (ptr == 4'(N_REGS - 1));
  assign ptr_next = ptr_last ? 4'd0 : ptr + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= RST_WAIT;
      cnt               <= '0;
      ptr               <= '0;
      address           <= '0;
      data_write        <= '0;
      indicador_maquina <= 1'b0;
      frame_valid       <= 1'b0;
      wr.wr_ack         <= 1'b0;
      for (int i = 0; i < N_REGS; i++) bank[i] <= '0;
`ifdef SECUENCIADOR_INIT_EN
      init_step         <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      wr.wr_ack   <= 1'b0;
      case (state)
        RST_WAIT: begin
          cnt <= '0;
`ifdef SECUENCIADOR_INIT_EN
          state             <= INIT;
          init_step         <= 1'b0;
          address           <= 8'h02;
          data_write        <= 8'h10;
          indicador_maquina <= 1'b1;
`else
          state             <= READ;
          address           <= reg_addr(4'd0);
          data_write        <= 8'h00;
          indicador_maquina <= 1'b0;
`endif
        end

        READ: begin
          if (slot_end) begin
            cnt        <= '0;
            bank[ptr]  <= data_vga;
            ptr        <= ptr_next;
            frame_valid <= ptr_last;
            // The address/data latched here stay frozen for the whole next slot
            if (wr.wr_req) begin
              state             <= WRITE;
              address           <= wr.wr_addr;
              data_write        <= wr.wr_data;
              indicador_maquina <= 1'b1;
            end else begin
              address           <= reg_addr(ptr_next);
              data_write        <= 8'h00;
              indicador_maquina <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WRITE: begin
          if (slot_end) begin
            // Always return to READ so a held wr_req cannot starve the sweep
            cnt               <= '0;
            state             <= READ;
            address           <= reg_addr(ptr);
            data_write        <= 8'h00;
            indicador_maquina <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            wr.wr_ack <= ack_next;
          end
        end

`ifdef SECUENCIADOR_INIT_EN
        INIT: begin
          if (slot_end) begin
            cnt <= '0;
            if (!init_step) begin
              init_step         <= 1'b1;
              address           <= 8'h00;
              data_write        <= 8'h00;
              indicador_maquina <= 1'b1;
            end else begin
              state             <= READ;
              address           <= reg_addr(4'd0);
              data_write        <= 8'h00;
              indicador_maquina <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        default: state <= RST_WAIT;
      endcase
    end
  end

  assign seg    = bank[0];
  assign min    = bank[1];
  assign hora   = bank[2];
  assign dia    = bank[3];
  assign mes    = bank[4];
  assign anio   = bank[5];
  assign seg_t  = bank[6];
  assign min_t  = bank[7];
  assign hora_t = bank[8];

endmodule

// File: tb/tb_secuenciador_rtc.sv
// tb/tb_secuenciador_rtc.sv - directed self-checking bench for secuenciador_rtc
`timescale 1ns/1ps
module tb_secuenciador_rtc;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] address, data_write, data_vga;
  logic       indicador_maquina, frame_valid;
  logic [7:0] seg, min, hora, dia, mes, anio, seg_t, min_t, hora_t;

  int npass = 0;
  int ntotal = 0;

  logic [7:0] map [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] exp_addr [0:5] = '{8'h21, 8'h30, 8'h22, 8'h30, 8'h23, 8'h24};
  logic       exp_ind  [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  secuenciador_rtc_if wr_bus ();

  secuenciador_rtc #(.TRANS_CYCLES(T), .N_REGS(9)) dut (
    .clk               (clk),
    .reset             (reset),
    .wr                (wr_bus),
    .address           (address),
    .data_write        (data_write),
    .indicador_maquina (indicador_maquina),
    .data_vga          (data_vga),
    .seg               (seg),
    .min               (min),
    .hora              (hora),
    .dia               (dia),
    .mes               (mes),
    .anio              (anio),
    .seg_t             (seg_t),
    .min_t             (min_t),
    .hora_t            (hora_t),
    .frame_valid       (frame_valid)
  );

  always #5 clk = ~clk;

  // Emulated protocol engine: returns 0x10 + map index of the current address
  always_comb begin
    data_vga = 8'hEE;
    for (int i = 0; i < 9; i++)
      if (address == map[i]) data_vga = 8'h10 + i[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, release and advance to the first cycle of the first READ slot
  task automatic start();
    int ia, ifv;
    ia = 0;
    ifv = 0;
    reset = 1'b0;
    wr_bus.wr_req = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
`ifdef SECUENCIADOR_INIT_EN
    chk("init0_addr", address, 8'h02);
    chk("init0_dw", data_write, 8'h10);
    chk("init0_ind", indicador_maquina, 1'b1);
    for (int i = 2; i <= 17; i++) begin
      cyc(1);
      if (wr_bus.wr_ack) ia++;
      if (frame_valid) ifv++;
      if (i == 9) begin
        chk("init1_addr", address, 8'h00);
        chk("init1_dw", data_write, 8'h00);
        chk("init1_ind", indicador_maquina, 1'b1);
      end
    end
    chk("init_ack", ia, 0);
    chk("init_fv", ifv, 0);
`endif
    chk("first_read_addr", address, 8'h21);
    chk("first_read_ind", indicador_maquina, 1'b0);
  endtask

  initial begin
    int first_fv, fvn, acks, ack_r, b2b, anyw;
    logic prev_w;
    wr_bus.wr_req  = 1'b0;
    wr_bus.wr_addr = 8'h00;
    wr_bus.wr_data = 8'h00;

    // Reset values
    reset = 1'b0;
    cyc(2);
    chk("rst_addr", address, 8'h00);
    chk("rst_ind", indicador_maquina, 1'b0);
    chk("rst_dw", data_write, 8'h00);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_ack", wr_bus.wr_ack, 1'b0);
    chk("rst_seg", seg, 8'h00);

    // Full sweep without writes
    start();
    first_fv = 0;
    fvn = 0;
    for (int r = 1; r <= 80; r++) begin
      if (r > 1) cyc(1);
      if (r <= 72) chk("sweep_addr", address, map[(r-1)/8]);
      if (r == 20) chk("sweep_dw", data_write, 8'h00);
      if (frame_valid) begin
        fvn++;
        if (first_fv == 0) first_fv = r;
      end
    end
    chk("first_fv", first_fv, 73);
    chk("fv_count", fvn, 1);
    chk("bank_seg", seg, 8'h10);
    chk("bank_min", min, 8'h11);
    chk("bank_anio", anio, 8'h15);
    chk("bank_seg_t", seg_t, 8'h16);
    chk("bank_hora_t", hora_t, 8'h18);

    // Single write inserted after read slot 1
    start();
    cyc(9);
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = 8'h22;
    wr_bus.wr_data = 8'h45;
    acks = 0;
    ack_r = 0;
    for (int r = 11; r <= 26; r++) begin
      cyc(1);
      if (r == 17) begin
        chk("w_addr", address, 8'h22);
        chk("w_dw", data_write, 8'h45);
        chk("w_ind", indicador_maquina, 1'b1);
        chk("cap_min", min, 8'h11);
      end
      if (r == 20) begin
        wr_bus.wr_addr = 8'h55;
        wr_bus.wr_data = 8'h99;
      end
      if (r == 23) begin
        chk("w_hold_addr", address, 8'h22);
        chk("w_hold_dw", data_write, 8'h45);
      end
      if (wr_bus.wr_ack) begin
        acks++;
        ack_r = r;
        wr_bus.wr_req = 1'b0;
      end
      if (r == 25) begin
        chk("resume_addr", address, 8'h23);
        chk("resume_ind", indicador_maquina, 1'b0);
        chk("resume_dw", data_write, 8'h00);
      end
    end
    chk("w_ack_n", acks, 1);
    chk("w_ack_cyc", ack_r, 24);

    // Held request: READ/WRITE alternate
    start();
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = 8'h30;
    wr_bus.wr_data = 8'h5A;
    acks = 0;
    b2b = 0;
    prev_w = 1'b0;
    for (int r = 1; r <= 48; r++) begin
      if (r > 1) cyc(1);
      if ((r - 1) % 8 == 0) begin
        chk("alt_ind", indicador_maquina, exp_ind[(r-1)/8]);
        chk("alt_addr", address, exp_addr[(r-1)/8]);
        if (indicador_maquina && prev_w) b2b++;
        prev_w = indicador_maquina;
      end
      if (wr_bus.wr_ack) acks++;
      if (r == 40) wr_bus.wr_req = 1'b0;
    end
    chk("alt_acks", acks, 2);
    chk("alt_b2b", b2b, 0);

    // Reset at cnt 5 of a WRITE slot
    start();
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = 8'h31;
    wr_bus.wr_data = 8'h77;
    acks = 0;
    for (int r = 2; r <= 14; r++) begin
      cyc(1);
      if (wr_bus.wr_ack) acks++;
      if (r == 9) wr_bus.wr_req = 1'b0;
    end
    chk("mid_ind", indicador_maquina, 1'b1);
    reset = 1'b0;
    cyc(1);
    if (wr_bus.wr_ack) acks++;
    chk("mid_rst_addr", address, 8'h00);
    chk("mid_rst_ind", indicador_maquina, 1'b0);
    chk("mid_rst_dw", data_write, 8'h00);
    chk("mid_rst_seg", seg, 8'h00);
    chk("mid_rst_fv", frame_valid, 1'b0);
    chk("mid_rst_ack", acks, 0);
    start();
    acks = 0;
    for (int r = 2; r <= 16; r++) begin
      cyc(1);
      if (wr_bus.wr_ack) acks++;
    end
    chk("mid_after_ack", acks, 0);

    // Short pulse inside a READ slot is not serviced
    start();
    cyc(1);
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = 8'h40;
    wr_bus.wr_data = 8'h01;
    cyc(3);
    wr_bus.wr_req = 1'b0;
    acks = 0;
    anyw = 0;
    for (int r = 6; r <= 24; r++) begin
      cyc(1);
      if (wr_bus.wr_ack) acks++;
      if (indicador_maquina) anyw++;
      if (r == 9) chk("pulse_addr", address, 8'h22);
    end
    chk("pulse_ack", acks, 0);
    chk("pulse_write", anyw, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/secuenciador_rtc.md
Name: secuenciador_rtc

Overview:
- Upstream of the RTC bus protocol engine (Protocolo_rtc). Drives its `address`, `DATA_WRITE` and `IndicadorMaquina` inputs in fixed-length transaction slots.
- Continuously sweeps the RTC time/date/timer registers and captures the returned `data_vga` byte into a shadow register bank for the VGA path.
- Inserts user write requests (time/date/timer edits) between read slots.

Parameters:
- TRANS_CYCLES, 256, clk cycles per protocol transaction slot; must be >= 4.
- N_REGS, 9, registers in the read sweep (fixed map below).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-low
- wr_req  in  1  level; write pending, held until wr_ack
- wr_addr  in  8  RTC register address for the write
- wr_data  in  8  byte to write
- wr_ack  out  1  1-cycle pulse, last cycle of the write slot
- address  out  8  to protocol `address`
- data_write  out  8  to protocol `DATA_WRITE`
- indicador_maquina  out  1  to protocol `IndicadorMaquina`; 1 = write slot, 0 = read slot
- data_vga  in  8  read byte returned by the protocol engine
- seg, min, hora, dia, mes, anio, seg_t, min_t, hora_t  out  8 each  shadow bank
- frame_valid  out  1  1-cycle pulse when a full sweep has been captured

Behaviour:
- Read map, index 0..8: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x41, 0x42, 0x43. These map to seg..anio, then seg_t..hora_t.
- Slot counter `cnt` runs 0..TRANS_CYCLES-1. The slot end is `cnt == TRANS_CYCLES-1`.
- `address`, `data_write` and `indicador_maquina` change only on the clock edge that starts a slot (`cnt` 0). They are stable for the whole slot.
- Reset (reset = 0 at a clk edge) applies the following values:
  - all outputs = 0;
  - cnt = 0, read pointer `ptr` = 0, write latch cleared;
  - state = RST_WAIT.
- Reset asserted mid-slot aborts the slot. No capture and no ack occur.
- States:
  - RST_WAIT: first cycle after reset release. Loads the slot-0 values (address = 0x21, indicador_maquina = 0) and goes to READ.
  - READ: indicador_maquina = 0, address = map[ptr].
    - At slot end: `data_vga` is sampled into bank[ptr], visible the next cycle.
    - ptr then increments. At 8 → 0 it wraps and frame_valid pulses in the same cycle as the bank[8] update.
    - Next state is WRITE if wr_req = 1 at slot end, else READ.
  - WRITE: address = wr_addr and data_write = wr_data, both latched at slot start. indicador_maquina = 1.
    - At slot end: wr_ack pulses and the next state is unconditionally READ.
    - ptr is not advanced and there is no capture.
- Fairness: at most one WRITE slot between consecutive READ slots. A continuously asserted wr_req gets alternating R/W slots.
- wr_req/wr_addr/wr_data changing during a WRITE slot has no effect on that slot.
- wr_req dropped before slot end is not serviced and gets no ack.
- Latency, no writes: full sweep = 9·TRANS_CYCLES cycles. First frame_valid occurs 1 + 9·TRANS_CYCLES cycles after reset release.
- Bank registers hold their value between captures. data_write = 0 during READ slots.

Optional Feature:
- Macro: SECUENCIADOR_INIT_EN.
- Defined:
  - after RST_WAIT, state INIT runs two WRITE slots before the first READ: address 0x02 ← 0x10, then address 0x00 ← 0x00.
  - wr_ack does not pulse for INIT slots and frame_valid does not fire.
  - wr_req raised during INIT waits until after the first READ slot.
  - first frame_valid moves to 1 + 11·TRANS_CYCLES.
- Undefined: the INIT state and its logic are absent; RST_WAIT → READ directly.

Test Plan (TRANS_CYCLES = 8, macro undefined unless stated):
- Reset release, data_vga driven = 0x10 + ptr:
  - address steps 0x21, 0x22, …, 0x43, each held 8 cycles;
  - frame_valid first high at cycle 73 after release;
  - seg = 0x10, hora_t = 0x18.
- wr_req = 1, wr_addr = 0x22, wr_data = 0x45 raised during read slot 1:
  - the next slot is WRITE with address 0x22, data_write 0x45, indicador_maquina = 1;
  - wr_ack fires once at its last cycle;
  - sweep resumes at address 0x23.
- wr_req held high for 40 cycles: slots alternate READ/WRITE, with no two consecutive WRITE slots.
- Reset pulsed at cnt = 5 of a WRITE slot: no wr_ack; all outputs = 0; restart at address 0x21.
- wr_req pulsed high for cycles 2–4 of a READ slot only: no WRITE slot and no wr_ack.
- SECUENCIADOR_INIT_EN defined:
  - first two slots are 0x02/0x10 then 0x00/0x00, both with indicador_maquina = 1;
  - no wr_ack;
  - first READ address is 0x21 at cycle 17.
